// File: rtl/riscv_mem_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter_rr_if
//  Description : Bus bundle for the N-port memory arbiter. Carries the
//                per-requester request/response strobes on one side and the
//                single memory request/response channel on the other.
//  Modports    : master - the arbiter (drives req_ready, resp_valid, mem_req_*)
//                slave  - the environment (requesters plus memory)
//  Signals     : req_valid/req_ready/req_rw [NUM_PORTS]
//                req_addr [NUM_PORTS*ADDR_BITS], port i at [i*ADDR_BITS +: ADDR_BITS]
//                resp_valid [NUM_PORTS]
//                mem_req_valid/ready/rw, mem_req_addr [ADDR_BITS],
//                mem_req_tag [TAG_BITS], mem_resp_valid, mem_resp_tag [TAG_BITS]
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

interface riscv_mem_arbiter_rr_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_BITS = `MEM_ADDR_BITS,
  parameter int TAG_BITS  = `MEM_TAG_BITS
);
  logic [NUM_PORTS-1:0]           req_valid;
  logic [NUM_PORTS-1:0]           req_ready;
  logic [NUM_PORTS-1:0]           req_rw;
  logic [NUM_PORTS*ADDR_BITS-1:0] req_addr;
  logic [NUM_PORTS-1:0]           resp_valid;
  logic                           mem_req_valid;
  logic                           mem_req_ready;
  logic                           mem_req_rw;
  logic [ADDR_BITS-1:0]           mem_req_addr;
  logic [TAG_BITS-1:0]            mem_req_tag;
  logic                           mem_resp_valid;
  logic [TAG_BITS-1:0]            mem_resp_tag;

  modport master (
    input  req_valid, req_rw, req_addr, mem_req_ready, mem_resp_valid, mem_resp_tag,
    output req_ready, resp_valid, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag
  );

  modport slave (
    output req_valid, req_rw, req_addr, mem_req_ready, mem_resp_valid, mem_resp_tag,
    input  req_ready, resp_valid, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag
  );
endinterface

`default_nettype wire

// File: rtl/riscv_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter_rr
//  Description : N-port arbiter between cache/prefetch requesters and a single
//                memory channel. Fixed-priority or round-robin selection, grant
//                locked until the memory accepts, in-flight cap, tag-based
//                response routing with a sticky bad-tag flag.
//  Ports       : clk          - sole clock, rising edge
//                reset_n      - asynchronous active-low reset
//                bus          - request/response bundle (master modport)
//                outstanding  - registered in-flight request count
//                err_bad_tag  - sticky: out-of-range tag or response with
//                               nothing outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module riscv_mem_arbiter_rr #(
  parameter int NUM_PORTS       = 2,               // 2..8
  parameter int ADDR_BITS       = `MEM_ADDR_BITS,
  parameter int TAG_BITS        = `MEM_TAG_BITS,   // 2**TAG_BITS >= NUM_PORTS
  parameter int MAX_OUTSTANDING = 4,               // 1..15
  parameter bit RR_MODE         = 1'b1             // 0 = fixed, 1 = round-robin
) (
  input  wire logic                                 clk,
  input  wire logic                                 reset_n,
  riscv_mem_arbiter_rr_if.master                    bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding,
  output logic                                      err_bad_tag
);

  localparam int c_ptr_w = $clog2(NUM_PORTS);
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_ptr_w-1:0]   r_lock_port;
  logic [c_ptr_w-1:0]   r_rr_ptr;
  logic [c_cnt_w-1:0]   r_outstanding;
  logic                 r_err;

  logic                 w_full;
  logic                 w_pick_found;
  logic [c_ptr_w-1:0]   w_pick_port;
  logic [c_ptr_w-1:0]   w_gnt_port;
  logic                 w_gnt_req;
  logic                 w_gnt_act;
  logic                 w_accept;
  logic                 w_tag_ok;
  logic                 w_dec;
  logic                 w_bad;

  function automatic logic [c_ptr_w-1:0] wrap_idx(input int base, input int off);
    return c_ptr_w'((base + off) % NUM_PORTS);
  endfunction

  // Full is judged on the registered count only, so a response arriving
  // while full unblocks requests one cycle later.
  assign w_full = (r_outstanding == c_max_out);

  // Scan from the highest offset down so the nearest valid port (relative to
  // the search base) is the last one written and therefore wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_port  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[wrap_idx(RR_MODE ? int'(r_rr_ptr) : 0, i)]) begin
        w_pick_found = 1'b1;
        w_pick_port  = wrap_idx(RR_MODE ? int'(r_rr_ptr) : 0, i);
      end
    end
  end

  // While locked only the held port matters; other requesters are ignored.
  assign w_gnt_port = (r_state == LOCKED) ? r_lock_port : w_pick_port;
  assign w_gnt_req  = (r_state == LOCKED) ? bus.req_valid[r_lock_port] : w_pick_found;
  assign w_gnt_act  = w_gnt_req & ~w_full & reset_n;
  assign w_accept   = w_gnt_act & bus.mem_req_ready;

  assign bus.mem_req_valid = w_gnt_act;
  assign bus.mem_req_tag   = w_gnt_act ? TAG_BITS'(w_gnt_port) : '0;

  always_comb begin
    bus.req_ready    = '0;
    bus.mem_req_rw   = 1'b0;
    bus.mem_req_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_gnt_act && (w_gnt_port == c_ptr_w'(i))) begin
        bus.req_ready[i] = bus.mem_req_ready;
        bus.mem_req_rw   = bus.req_rw[i];
        bus.mem_req_addr = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  // Response routing: a tag beyond the port range strobes nobody.
  assign w_tag_ok = (int'(bus.mem_resp_tag) < NUM_PORTS);
  assign w_dec    = bus.mem_resp_valid & w_tag_ok & (r_outstanding != '0);
  assign w_bad    = bus.mem_resp_valid & (~w_tag_ok | (r_outstanding == '0));

  always_comb begin
    bus.resp_valid = '0;
    for (int t = 0; t < NUM_PORTS; t++) begin
      bus.resp_valid[t] = reset_n & bus.mem_resp_valid & (bus.mem_resp_tag == TAG_BITS'(t));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_lock_port   <= '0;
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      // The pointer only advances on a real transfer, never on an abandoned lock.
      if (w_accept) begin
        r_rr_ptr <= (w_gnt_port == c_last) ? '0 : w_gnt_port + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_gnt_act && !bus.mem_req_ready) begin
            r_state     <= LOCKED;
            r_lock_port <= w_pick_port;
          end
        end
        LOCKED: begin
          if (w_accept || !bus.req_valid[r_lock_port]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      case ({w_accept, w_dec})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding = r_outstanding;
  assign err_bad_tag = r_err;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_mem_arbiter_rr
//  Description : Directed self-checking bench. Instance A: 4 ports,
//                round-robin, cap 2. Instance B: 3 ports, fixed priority,
//                cap 4, 2-bit tags. Accepted requests are checked against a
//                queue of expected {tag, addr, rw} records.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter_rr;

  logic clk;
  logic reset_n;
  logic [1:0] a_out;
  logic       a_err;
  logic [2:0] b_out;
  logic       b_err;

  int vectors;
  int miscompares;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  riscv_mem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_BITS(16), .TAG_BITS(3)) a_if ();
  riscv_mem_arbiter_rr_if #(.NUM_PORTS(3), .ADDR_BITS(16), .TAG_BITS(2)) b_if ();

  riscv_mem_arbiter_rr #(
    .NUM_PORTS(4), .ADDR_BITS(16), .TAG_BITS(3), .MAX_OUTSTANDING(2), .RR_MODE(1'b1)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.master),
    .outstanding(a_out), .err_bad_tag(a_err)
  );

  riscv_mem_arbiter_rr #(
    .NUM_PORTS(3), .ADDR_BITS(16), .TAG_BITS(2), .MAX_OUTSTANDING(4), .RR_MODE(1'b0)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.master),
    .outstanding(b_out), .err_bad_tag(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int tag, input logic [15:0] addr, input logic rw);
    return {8'(tag), addr, 7'b0, rw};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted request must match the oldest expected record.
  always @(negedge clk) begin
    if (a_if.mem_req_valid && a_if.mem_req_ready) begin
      chk("a_accept_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0)
        chk("a_accept", {8'(a_if.mem_req_tag), a_if.mem_req_addr, 7'b0, a_if.mem_req_rw},
            exp_a.pop_front());
    end
    if (b_if.mem_req_valid && b_if.mem_req_ready) begin
      chk("b_accept_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0)
        chk("b_accept", {8'(b_if.mem_req_tag), b_if.mem_req_addr, 7'b0, b_if.mem_req_rw},
            exp_b.pop_front());
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    a_if.req_valid = 4'hF; a_if.req_rw = 4'b1010;
    a_if.req_addr = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
    a_if.mem_req_ready = 1'b1; a_if.mem_resp_valid = 1'b1; a_if.mem_resp_tag = 3'd1;
    b_if.req_valid = 3'b000; b_if.req_rw = 3'b010;
    b_if.req_addr = {16'hB002, 16'hB001, 16'hB000};
    b_if.mem_req_ready = 1'b0; b_if.mem_resp_valid = 1'b0; b_if.mem_resp_tag = 2'd0;

    // Reset: outputs forced low even with requests and a response pending
    #2;
    chk("rst_a_mem_req_valid", 32'(a_if.mem_req_valid), 0);
    chk("rst_a_req_ready",     32'(a_if.req_ready), 0);
    chk("rst_a_resp_valid",    32'(a_if.resp_valid), 0);
    chk("rst_a_addr",          32'(a_if.mem_req_addr), 0);
    chk("rst_a_out",           32'(a_out), 0);
    chk("rst_b_err",           32'(b_err), 0);
    cyc();
    reset_n = 1'b1;
    a_if.mem_resp_valid = 1'b0;

    // Round-robin: all valid, responses returned next cycle -> grants 0,1,2,3,0
    exp_a.push_back(pk(0, 16'h4000, 1'b0));
    #1; chk("rr0_out", 32'(a_out), 0); chk("rr0_tag", 32'(a_if.mem_req_tag), 0);
    cyc();
    for (int g = 1; g <= 4; g++) begin
      a_if.mem_resp_valid = 1'b1; a_if.mem_resp_tag = 3'(g - 1);
      exp_a.push_back(pk(g % 4, 16'h4000 + 16'(g % 4), (g % 2) == 1));
      #1;
      chk("rr_tag", 32'(a_if.mem_req_tag), 32'(g % 4));
      chk("rr_resp_valid", 32'(a_if.resp_valid), 32'(1 << (g - 1)));
      chk("rr_out_steady", 32'(a_out), 1);
      cyc();
    end
    a_if.req_valid = 4'h0; a_if.mem_resp_tag = 3'd0;
    #1; chk("drain_resp_valid", 32'(a_if.resp_valid), 4'b0001);
    chk("drain_no_req", 32'(a_if.mem_req_valid), 0);
    cyc();
    a_if.mem_resp_valid = 1'b0;

    // Lock: port 2 wins with memory stalled, port 0 arrives meanwhile
    a_if.req_valid = 4'b0100; a_if.mem_req_ready = 1'b0;
    #1; chk("lock_out0", 32'(a_out), 0);
    chk("lock_valid", 32'(a_if.mem_req_valid), 1);
    chk("lock_addr1", 32'(a_if.mem_req_addr), 32'h4002);
    chk("lock_ready1", 32'(a_if.req_ready), 0);
    cyc();
    a_if.req_valid = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      #1; chk("lock_addr_held", 32'(a_if.mem_req_addr), 32'h4002);
      chk("lock_tag_held", 32'(a_if.mem_req_tag), 2);
      cyc();
    end
    a_if.mem_req_ready = 1'b1;
    exp_a.push_back(pk(2, 16'h4002, 1'b0));
    #1; chk("lock_ready4", 32'(a_if.req_ready), 4'b0100);
    cyc();
    a_if.req_valid = 4'b0001;
    exp_a.push_back(pk(0, 16'h4000, 1'b0));
    #1; chk("after_lock_tag", 32'(a_if.mem_req_tag), 0);
    cyc();

    // Full at cap 2: nothing goes out until a response has been registered
    a_if.req_valid = 4'b0010;
    #1; chk("full_out", 32'(a_out), 2);
    chk("full_no_req", 32'(a_if.mem_req_valid), 0);
    chk("full_no_ready", 32'(a_if.req_ready), 0);
    chk("full_tag_zero", 32'(a_if.mem_req_tag), 0);
    cyc();
    a_if.mem_resp_valid = 1'b1; a_if.mem_resp_tag = 3'd1;
    #1; chk("full_resp_valid", 32'(a_if.resp_valid), 4'b0010);
    chk("full_still_blocked", 32'(a_if.mem_req_valid), 0);
    cyc();
    a_if.mem_resp_valid = 1'b0;
    exp_a.push_back(pk(1, 16'h4001, 1'b1));
    #1; chk("unblock_valid", 32'(a_if.mem_req_valid), 1);
    chk("unblock_out", 32'(a_out), 1);
    cyc();
    a_if.req_valid = 4'h0;
    a_if.mem_resp_valid = 1'b1; a_if.mem_resp_tag = 3'd0;
    cyc();
    a_if.mem_resp_tag = 3'd1;
    cyc();
    a_if.mem_resp_valid = 1'b0;
    #1; chk("drained_out", 32'(a_out), 0);
    chk("a_no_err", 32'(a_err), 0);

    // Abandoned lock: pointer must stay at 2
    a_if.req_valid = 4'b1000; a_if.mem_req_ready = 1'b0;
    #1; chk("abandon_tag", 32'(a_if.mem_req_tag), 3);
    cyc();
    a_if.req_valid = 4'b0010; a_if.mem_req_ready = 1'b1;
    #1; chk("abandon_no_req", 32'(a_if.mem_req_valid), 0);
    chk("abandon_no_ready", 32'(a_if.req_ready), 0);
    cyc();
    a_if.req_valid = 4'b1010;
    exp_a.push_back(pk(3, 16'h4003, 1'b1));
    #1; chk("abandon_ptr_kept", 32'(a_if.mem_req_tag), 3);
    cyc();
    a_if.req_valid = 4'h0;

    // Fixed priority, 3 ports: lowest index wins and starves others
    b_if.req_valid = 3'b011; b_if.mem_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_b.push_back(pk(0, 16'hB000, 1'b0));
      #1; chk("fix_tag0", 32'(b_if.mem_req_tag), 0);
      chk("fix_ready0", 32'(b_if.req_ready), 3'b001);
      cyc();
    end
    b_if.req_valid = 3'b110;
    exp_b.push_back(pk(1, 16'hB001, 1'b1));
    #1; chk("fix_tag1", 32'(b_if.mem_req_tag), 1);
    cyc();
    b_if.req_valid = 3'b100;
    exp_b.push_back(pk(2, 16'hB002, 1'b0));
    #1; chk("fix_out3", 32'(b_out), 3);
    cyc();
    b_if.req_valid = 3'b001;
    b_if.mem_resp_valid = 1'b1; b_if.mem_resp_tag = 2'd3;
    #1; chk("b_full_no_req", 32'(b_if.mem_req_valid), 0);
    chk("bad_tag_no_resp", 32'(b_if.resp_valid), 0);
    cyc();
    b_if.mem_resp_tag = 2'd2;
    #1; chk("bad_tag_err", 32'(b_err), 1);
    chk("bad_tag_out_kept", 32'(b_out), 4);
    chk("b_resp_valid2", 32'(b_if.resp_valid), 3'b100);
    cyc();
    b_if.mem_resp_valid = 1'b0;
    exp_b.push_back(pk(0, 16'hB000, 1'b0));
    #1; chk("b_out_after_resp", 32'(b_out), 3);
    chk("b_err_sticky", 32'(b_err), 1);
    chk("b_unblock", 32'(b_if.mem_req_valid), 1);
    cyc();
    b_if.req_valid = 3'b000;

    // Asynchronous reset in the middle of a lock
    a_if.req_valid = 4'b0001; a_if.mem_req_ready = 1'b0;
    cyc();
    #1; chk("pre_rst_lock", 32'(a_if.mem_req_addr), 32'h4000);
    #1; reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_if.mem_req_valid), 0);
    chk("arst_addr", 32'(a_if.mem_req_addr), 0);
    chk("arst_tag", 32'(a_if.mem_req_tag), 0);
    chk("arst_a_out", 32'(a_out), 0);
    chk("arst_b_out", 32'(b_out), 0);
    chk("arst_b_err", 32'(b_err), 0);
    cyc();
    reset_n = 1'b1;
    a_if.req_valid = 4'h0;
    a_if.mem_resp_valid = 1'b1; a_if.mem_resp_tag = 3'd0;
    b_if.mem_resp_valid = 1'b1; b_if.mem_resp_tag = 2'd1;
    cyc();
    a_if.mem_resp_valid = 1'b0; b_if.mem_resp_valid = 1'b0;
    #1; chk("stale_resp_err_a", 32'(a_err), 1);
    chk("stale_resp_err_b", 32'(b_err), 1);
    chk("stale_no_underflow", 32'(a_out), 0);
    cyc();

    chk("a_queue_drained", 32'(exp_a.size()), 0);
    chk("b_queue_drained", 32'(exp_b.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
